// File: rtl/alu_mult_seq_pkg.sv
// Shared constants for the shift-add multiplier: ALU control codes, widths, FSM states.
// Optional signed mode is enabled by defining MULT_SIGNED_EN.
package alu_mult_seq_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned CTRL_W = 4;

  localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_SLL  = 4'b0011;
  localparam logic [CTRL_W-1:0] ALU_LUI  = 4'b0100;
  localparam logic [CTRL_W-1:0] ALU_SLLV = 4'b0101;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_SLT  = 4'b0111;
  localparam logic [CTRL_W-1:0] ALU_NOR  = 4'b1100;
  localparam logic [CTRL_W-1:0] ALU_NAND = 4'b1101;

  localparam logic [CTRL_W-1:0] ALU_ADD_CODE = ALU_ADD;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  // Partial product as seen by the datapath: hi accumulates, lo shifts out multiplier bits.
  typedef struct packed {
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } prod_t;

  // Two's-complement magnitude of v when en is set and v is negative.
  function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v, input logic en);
    return (en && v[DATA_W-1]) ? (~v + DATA_W'(1)) : v;
  endfunction

endpackage

// File: rtl/alu_mult_seq_if.sv
// Request/response and shared-ALU signals of the multiplier controller.
// signed_op exists only when MULT_SIGNED_EN is defined.
interface alu_mult_seq_if;
  import alu_mult_seq_pkg::*;

  logic              start;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic              busy;
  logic              done;
  logic [PROD_W-1:0] product;
  logic [DATA_W-1:0] alu_src1;
  logic [DATA_W-1:0] alu_src2;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [DATA_W-1:0] alu_result;
`ifdef MULT_SIGNED_EN
  logic              signed_op;
`endif

  modport master (
`ifdef MULT_SIGNED_EN
    output signed_op,
`endif
    output start, mcand, mplier, alu_result,
    input  busy, done, product, alu_src1, alu_src2, alu_ctrl
  );

  modport slave (
`ifdef MULT_SIGNED_EN
    input  signed_op,
`endif
    input  start, mcand, mplier, alu_result,
    output busy, done, product, alu_src1, alu_src2, alu_ctrl
  );

endinterface

// File: rtl/alu_mult_seq.sv
// Iterative 32x32->64 shift-add multiplier that borrows the shared ALU for every add.
// Define MULT_SIGNED_EN for signed operands (adds signed_op and a FIX negation state).
module alu_mult_seq
  import alu_mult_seq_pkg::*;
(
  input logic         clk_i,
  input logic         rst_i,
  alu_mult_seq_if.slave bus
);

  state_t            state, state_n;
  prod_t             prod, prod_n;
  logic [CNT_W-1:0]  count, count_n;
  logic [DATA_W-1:0] mcand_r, mcand_n;
  logic              busy_r, busy_n;
  logic              done_r, done_n;
  logic [DATA_W-1:0] src1_r, src1_n;
  logic [DATA_W-1:0] src2_r, src2_n;
  logic [CTRL_W-1:0] ctrl_r;
  logic [DATA_W-1:0] sum;
  logic              carry;
  logic              sgn;

`ifdef MULT_SIGNED_EN
  logic              neg_r, neg_n;
  assign sgn = bus.signed_op;
`else
  assign sgn = 1'b0;
`endif

  // The ALU has no carry-out: an unsigned add overflowed iff the sum wrapped below hi.
  assign sum   = bus.alu_result;
  assign carry = (sum < prod.hi);

  // Next-state and datapath; ALU operands are registered one cycle ahead from the next values.
  always_comb begin
    state_n = state;
    prod_n  = prod;
    count_n = count;
    mcand_n = mcand_r;
`ifdef MULT_SIGNED_EN
    neg_n   = neg_r;
`endif

    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          mcand_n     = magnitude(bus.mcand, sgn);
          prod_n.hi   = '0;
          prod_n.lo   = magnitude(bus.mplier, sgn);
          count_n     = '0;
`ifdef MULT_SIGNED_EN
          neg_n       = sgn & (bus.mcand[DATA_W-1] ^ bus.mplier[DATA_W-1]);
`endif
          state_n     = ST_CALC;
        end
      end
      ST_CALC: begin
        prod_n  = {carry, sum, prod.lo[DATA_W-1:1]};
        count_n = count + CNT_W'(1);
        if (count == CNT_W'(DATA_W - 1)) begin
`ifdef MULT_SIGNED_EN
          state_n = ST_FIX;
`else
          state_n = ST_DONE;
`endif
        end
      end
      ST_FIX: begin
`ifdef MULT_SIGNED_EN
        if (neg_r) begin
          prod_n = prod_t'(PROD_W'(0) - PROD_W'(prod));
        end
`endif
        state_n = ST_DONE;
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    busy_n = (state_n != ST_IDLE);
    done_n = (state_n == ST_DONE);
    src1_n = (state_n == ST_CALC) ? prod_n.hi : '0;
    src2_n = ((state_n == ST_CALC) && prod_n.lo[0]) ? mcand_n : '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state   <= ST_IDLE;
      prod    <= '0;
      count   <= '0;
      mcand_r <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      src1_r  <= '0;
      src2_r  <= '0;
      ctrl_r  <= ALU_ADD_CODE;
`ifdef MULT_SIGNED_EN
      neg_r   <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      prod    <= prod_n;
      count   <= count_n;
      mcand_r <= mcand_n;
      busy_r  <= busy_n;
      done_r  <= done_n;
      src1_r  <= src1_n;
      src2_r  <= src2_n;
      ctrl_r  <= ALU_ADD_CODE;
`ifdef MULT_SIGNED_EN
      neg_r   <= neg_n;
`endif
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.product  = PROD_W'(prod);
  assign bus.alu_src1 = src1_r;
  assign bus.alu_src2 = src2_r;
  assign bus.alu_ctrl = ctrl_r;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Randomized self-checking bench for alu_mult_seq with a behavioural ALU and product model.
// Signed cases are exercised when MULT_SIGNED_EN is defined.
module tb_alu_mult_seq;
  import alu_mult_seq_pkg::*;

`ifdef MULT_SIGNED_EN
  localparam int  EXP_LAT    = 34;
  localparam bit  HAS_SIGNED = 1'b1;
`else
  localparam int  EXP_LAT    = 33;
  localparam bit  HAS_SIGNED = 1'b0;
`endif

  logic clk_i;
  logic rst_i;
  int   n_cmp;
  int   n_err;
  logic [63:0] prev_exp;

  alu_mult_seq_if bus();

  alu_mult_seq dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  // Shared ALU: combinational, answers the control code the controller presents.
  always_comb begin
    case (bus.alu_ctrl)
      ALU_ADD: bus.alu_result = bus.alu_src1 + bus.alu_src2;
      ALU_SUB: bus.alu_result = bus.alu_src1 - bus.alu_src2;
      ALU_AND: bus.alu_result = bus.alu_src1 & bus.alu_src2;
      ALU_OR:  bus.alu_result = bus.alu_src1 | bus.alu_src2;
      default: bus.alu_result = '0;
    endcase
  end

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit sg);
    logic [63:0] ea, eb;
    ea = sg ? {{32{a[31]}}, a} : {32'b0, a};
    eb = sg ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  task automatic drive(input logic [31:0] mc, input logic [31:0] mp, input bit sg);
    bus.mcand  = mc;
    bus.mplier = mp;
    bus.start  = 1'b1;
`ifdef MULT_SIGNED_EN
    bus.signed_op = sg;
`endif
  endtask

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input logic [31:0] mc, input logic [31:0] mp, input bit sg,
                        input bit repulse, input bit from_done, input bit zero_src);
    logic [63:0] exp;
    int lat;
    exp = ref_mul(mc, mp, sg);
    if (from_done) drive(mc, mp, sg);
    @(negedge clk_i);
    check("idle_busy", 64'(bus.busy), 64'd0);
    check("idle_done", 64'(bus.done), 64'd0);
    check("idle_product_held", bus.product, prev_exp);
    if (!from_done) drive(mc, mp, sg);
    @(negedge clk_i);
    bus.start = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      if (bus.done) begin
        lat = n;
        break;
      end
      check("calc_busy", 64'(bus.busy), 64'd1);
      check("calc_ctrl", 64'(bus.alu_ctrl), 64'(ALU_ADD));
      if (zero_src) check("zero_src2", 64'(bus.alu_src2), 64'd0);
      if (repulse && n == 10) drive($urandom, $urandom, 1'b0);
      if (repulse && n == 11) bus.start = 1'b0;
      @(negedge clk_i);
    end
    check("latency", 64'(lat), 64'(EXP_LAT));
    check("done_busy", 64'(bus.busy), 64'd1);
    check("done_ctrl", 64'(bus.alu_ctrl), 64'(ALU_ADD));
    check("product", bus.product, exp);
    prev_exp = exp;
  endtask

  initial begin
    int seen;
    logic [31:0] a, b;
    bit sg;
    n_cmp = 0;
    n_err = 0;
    prev_exp = '0;
    rst_i = 1'b0;
    bus.start = 1'b0;
    bus.mcand = '0;
    bus.mplier = '0;
`ifdef MULT_SIGNED_EN
    bus.signed_op = 1'b0;
`endif
    repeat (2) @(negedge clk_i);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_product", bus.product, 64'd0);
    check("rst_src1", 64'(bus.alu_src1), 64'd0);
    check("rst_src2", 64'(bus.alu_src2), 64'd0);
    check("rst_ctrl", 64'(bus.alu_ctrl), 64'(ALU_ADD));
    rst_i = 1'b1;

    run_op(32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    check("3x5", bus.product, 64'h0000_0000_0000_000F);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
    check("max_x_max", bus.product, 64'hFFFF_FFFE_0000_0001);
    run_op(32'd0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b1);
    run_op(32'd7, 32'd9, 1'b0, 1'b1, 1'b0, 1'b0);
    check("7x9_repulse", bus.product, 64'd63);
    run_op(32'd2, 32'd6, 1'b0, 1'b0, 1'b1, 1'b0);

    // Abort mid-calculation with a one-edge reset.
    @(negedge clk_i);
    drive($urandom, $urandom, 1'b0);
    @(negedge clk_i);
    bus.start = 1'b0;
    repeat (14) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_product", bus.product, 64'd0);
    check("abort_src1", 64'(bus.alu_src1), 64'd0);
    check("abort_src2", 64'(bus.alu_src2), 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (bus.done) seen++;
    end
    check("abort_no_done", 64'(seen), 64'd0);
    prev_exp = '0;
    run_op(32'd2, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    check("2x2", bus.product, 64'd4);

`ifdef MULT_SIGNED_EN
    run_op(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    check("neg3x5_signed", bus.product, 64'hFFFF_FFFF_FFFF_FFF1);
    run_op(32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    check("neg3x5_unsigned", bus.product, 64'h0000_0004_FFFF_FFF1);
`endif

    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: a = 32'h8000_0000;
        1: b = 32'hFFFF_FFFF;
        2: a = 32'd0;
        default: ;
      endcase
      sg = HAS_SIGNED && ($urandom_range(0, 1) == 1);
      run_op(a, b, sg, 1'b0, (i % 4) == 3, a == 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
